// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrated multiplexer.
// Optional forced-select mode is enabled in the top by defining RR_MUX_FORCE_EN.
package rr_mux_pkg;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 8;

  // Modulo-n increment of a channel index; n need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_pick.sv
// Combinational round-robin picker: grants the first requester after i_last_grant,
// wrapping modulo NUM_CH, using a double-width rotate and a lowest-bit priority encode.
module rr_mux_pick
  import rr_mux_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_last_grant,
  output logic [CH_W-1:0]   o_grant,
  output logic              o_gnt_any
);

  int                w_start;
  int                w_offset;
  int                w_sum;
  logic [NUM_CH-1:0] w_rot;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_start  = rr_next(int'(i_last_grant), NUM_CH);
    // Rotating the doubled vector puts channel w_start at bit 0.
    w_rot    = NUM_CH'({i_req, i_req} >> w_start);
    w_offset = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_offset = i;
    end
    w_sum = w_start + w_offset;
    if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
    o_grant   = CH_W'(w_sum);
    o_gnt_any = |i_req;
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel round-robin arbitrated mux with a registered valid/ready output stage.
// Define RR_MUX_FORCE_EN to add force_en/force_sel for a fixed-select mux mode.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
`ifdef RR_MUX_FORCE_EN
  input  logic                     force_en,
  input  logic [CH_W-1:0]          force_sel,
`endif
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_last_grant;

  logic [NUM_CH-1:0] w_req;
  logic [CH_W-1:0]   w_grant;
  logic              w_gnt_any;
  logic              w_load;
  logic              w_xfer;
  logic              w_upd_last;

`ifdef RR_MUX_FORCE_EN
  // Forced mode narrows eligibility to one channel and freezes the rotation point.
  always_comb begin
    w_req      = in_valid;
    w_upd_last = 1'b1;
    if (force_en) begin
      w_upd_last = 1'b0;
      w_req      = '0;
      if ({1'b0, force_sel} < (CH_W + 1)'(NUM_CH))
        w_req = in_valid & (NUM_CH'(1) << force_sel);
    end
  end
`else
  assign w_req      = in_valid;
  assign w_upd_last = 1'b1;
`endif

  rr_mux_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_gnt_any    (w_gnt_any)
  );

  assign w_load   = ~r_out_valid | out_ready;
  assign w_xfer   = w_load & w_gnt_any;
  assign in_ready = (w_xfer && !rst) ? (NUM_CH'(1) << w_grant) : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else if (w_load) begin
      if (w_gnt_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[int'(w_grant)*DATA_W +: DATA_W];
        r_out_ch    <= w_grant;
        if (w_upd_last) r_last_grant <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
